mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
Round-robin controller for a shared 4-to-1 mux datapath. Four requesters each present a DW-bit word (w0..w3) plus a request bit. The block arbitrates between them and drives the mux select. It registers the selected word with a valid/ready handshake toward one downstream consumer, so the shared mux is never driven by two requesters at once.

Parameters:
DW, 3, width of each requester word and of output f
PTR_RST, 0, round-robin pointer value after reset (0..3)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
req  in  4  request bits, req[i] belongs to requester i
w0  in  DW  requester 0 data
w1  in  DW  requester 1 data
w2  in  DW  requester 2 data
w3  in  DW  requester 3 data
ready  in  1  downstream accepts f this cycle
s  out  2  mux select / index of the current grant
gnt  out  4  one-hot grant; all zero when idle
f  out  DW  registered selected word
valid  out  1  f holds a granted word

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: s=0, gnt=4'b0000, f=0, valid=0, ptr=PTR_RST, state=IDLE. rst dominates every other input, including in the middle of a transaction; any pending grant is dropped with no handshake.
- States: IDLE, BUSY.
- Pick function: scan requesters cyclically starting at ptr (ptr, ptr+1, ..., mod 4). The first i with req[i]=1 wins.
- IDLE with req!=0:
  - next edge: s=win, gnt=1<<win, f=w[win] (snapshot), valid=1, go to BUSY.
  - Latency is 1 cycle from req being sampled to valid.
- IDLE with req==0: all outputs hold at their idle values.
- BUSY with ready=0: s, gnt, f and valid hold stable.
  - Changes on w*/req are ignored.
  - A requester dropping req does not cancel its grant.
- BUSY with ready=1 (handshake):
  - ptr <= s+1, wrapping 3 -> 0.
  - Re-arbitrate this same cycle from the new ptr using the current req, with the current winner's bit masked.
  - Win: load the new grant, valid stays 1, back-to-back with no bubble.
  - No win: valid=0, gnt=0, go to IDLE. s and f keep their last values.
- A requester whose req stays high across the handshake is not re-granted until the others are served. This follows from the mask plus the ptr advance.
- f is a registered copy; width DW; no arithmetic performed on it.
- gnt is always one-hot or zero. valid=1 if and only if gnt!=0.

Optional Feature:
Macro ARB_FIXED_PRIO_EN.
- Defined: ptr is tied to 0 and never advances; req[0] has highest priority, req[3] lowest. The handshake mask remains, so the same requester is never granted twice back-to-back while others wait for one slot.
- Undefined: round-robin behaviour as above.

Decomposition:
- Package mux_arb_pkg:
  - REQ_N=4, SEL_W=2, DW_DEF=3
  - state typedef {IDLE, BUSY}
  - function next_ptr (wrap mod 4)
- One sub-module: rr_pick4, purely combinational. Inputs req[3:0], mask[3:0], ptr[1:0]. Outputs win[1:0] and any.
- Top level: the state machine, ptr register, output registers and the 4:1 data select.

Test Plan:
- Reset mid-BUSY: grant req=4'b0100, hold ready=0, assert rst one cycle -> next edge valid=0, gnt=0, s=0, f=0; ptr returns to 0.
- Single request: w0=3'b001, w1=3'b010, w2=3'b011, w3=3'b100, ptr=0, req=4'b0010 -> one cycle later s=1, gnt=4'b0010, f=3'b010, valid=1; with ready=1 -> IDLE, valid=0.
- Round-robin fairness: req=4'b1111 held, ready=1 constant -> s sequence 0,1,2,3,0,... on consecutive cycles; f = 001, 010, 011, 100 with w static; valid stays 1, no bubbles.
- Backpressure: grant requester 2 with ready=0 for 3 cycles while w2 increments each cycle and req[2] drops -> s=2 and f=3'b011 stay frozen; first ready=1 completes the transfer.
- Masking and wrap: ptr=3, req=4'b1001 -> grant 3, f=w3=3'b100; handshake with req still 4'b1001 -> next grant is 0 (ptr wrapped to 0), not 3.
- ARB_FIXED_PRIO_EN defined, req=4'b1100 continuous, ready=1 -> grants alternate 2,3,2,3 through the mask; with req=4'b1111 -> grants 0,1,0,1.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the 4-way round-robin mux arbiter.
//   REQ_N  : number of requesters
//   SEL_W  : width of the mux select / round-robin pointer
//   DW_DEF : default requester word width
package mux_arb_pkg;

  localparam int REQ_N  = 4;
  localparam int SEL_W  = 2;
  localparam int DW_DEF = 3;

  typedef enum logic {IDLE, BUSY} state_t;

  // Pointer advance; the 2-bit result wraps 3 -> 0 naturally.
  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] p);
    return p + 2'd1;
  endfunction

  function automatic logic [REQ_N-1:0] onehot(input logic [SEL_W-1:0] i);
    logic [REQ_N-1:0] o;
    o    = '0;
    o[i] = 1'b1;
    return o;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational cyclic picker: scans req & ~mask starting at ptr
// (ptr, ptr+1, ... mod 4) and returns the first set index.
//   req  : request bits
//   mask : requesters excluded from this pick
//   ptr  : scan start position
//   win  : winning index (don't-care when any=0)
//   any  : at least one unmasked request present
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [REQ_N-1:0] req,
  input  logic [REQ_N-1:0] mask,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] win,
  output logic             any
);

  logic [REQ_N-1:0] cand;
  assign cand = req & ~mask;
  assign any  = |cand;

  // Walk from the farthest offset down to offset 0 so the candidate
  // closest to ptr is the last (and therefore final) assignment.
  always_comb begin
    logic [SEL_W-1:0] idx;
    idx = '0;
    win = ptr;
    for (int k = REQ_N-1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (cand[idx]) win = idx;
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin controller for a shared 4:1 mux. Grants one requester at a
// time, snapshots its word into f and holds it under a valid/ready
// handshake. On a handshake it re-arbitrates in the same cycle with the
// current winner masked, giving back-to-back grants with no bubble.
//   clk, rst     : clock, synchronous active-high reset
//   req[3:0]     : request bits
//   w0..w3       : requester words (DW bits)
//   ready        : downstream accepts f
//   s            : mux select / current grant index
//   gnt          : one-hot grant, zero when idle
//   f            : registered selected word
//   valid        : f holds a granted word
// Build option: ARB_FIXED_PRIO_EN -- pointer tied to 0 (req[0] highest
// priority); the handshake mask still prevents back-to-back re-grants.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int PTR_RST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REQ_N-1:0] req,
  input  logic [DW-1:0]    w0,
  input  logic [DW-1:0]    w1,
  input  logic [DW-1:0]    w2,
  input  logic [DW-1:0]    w3,
  input  logic             ready,
  output logic [SEL_W-1:0] s,
  output logic [REQ_N-1:0] gnt,
  output logic [DW-1:0]    f,
  output logic             valid
);

  state_t                    state;
  logic [REQ_N-1:0][DW-1:0]  w_arr;
  logic [SEL_W-1:0]          pick_ptr;
  logic [REQ_N-1:0]          pick_mask;
  logic [SEL_W-1:0]          win;
  logic                      any;

  assign w_arr = {w3, w2, w1, w0};

`ifdef ARB_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  logic [SEL_W-1:0] ptr;
  // In BUSY the pick only matters on a handshake, where it must start
  // from the already-advanced pointer.
  assign pick_ptr = (state == BUSY) ? next_ptr(s) : ptr;
`endif

  // Only the handshake re-arbitration excludes the current winner.
  assign pick_mask = (state == BUSY) ? gnt : '0;

  rr_pick4 u_pick (
    .req  (req),
    .mask (pick_mask),
    .ptr  (pick_ptr),
    .win  (win),
    .any  (any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s     <= '0;
      gnt   <= '0;
      f     <= '0;
      valid <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      ptr   <= SEL_W'(PTR_RST);
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            s     <= win;
            gnt   <= onehot(win);
            f     <= w_arr[win];
            valid <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (ready) begin
`ifndef ARB_FIXED_PRIO_EN
            ptr <= next_ptr(s);
`endif
            if (any) begin
              s     <= win;
              gnt   <= onehot(win);
              f     <= w_arr[win];
            end else begin
              // s and f keep the last transfer for observability.
              gnt   <= '0;
              valid <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [2:0] w0, w1, w2, w3;
  logic       ready;
  logic [1:0] s;
  logic [3:0] gnt;
  logic [2:0] f;
  logic       valid;

  int errors = 0;
  int checks = 0;

  // reference model state
  int         m_ptr, m_s, m_f;
  logic [3:0] m_gnt;
  bit         m_valid, m_busy;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.DW(3), .PTR_RST(0)) dut (
    .clk(clk), .rst(rst), .req(req),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3),
    .ready(ready), .s(s), .gnt(gnt), .f(f), .valid(valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] rq, input int p);
    for (int k = 0; k < 4; k++)
      if (rq[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic int word(input int i);
    case (i)
      0: return int'(w0);
      1: return int'(w1);
      2: return int'(w2);
      default: return int'(w3);
    endcase
  endfunction

  function automatic int start_ptr();
`ifdef ARB_FIXED_PRIO_EN
    return 0;
`else
    return m_ptr;
`endif
  endfunction

  task automatic grant(input int wn);
    m_s = wn; m_gnt = 4'(1 << wn); m_f = word(wn); m_valid = 1; m_busy = 1;
  endtask

  // Drive one cycle of inputs, advance the model by one edge, compare.
  task automatic tick(input bit r, input logic [3:0] rq, input bit rdy);
    int wn;
    rst = r; req = rq; ready = rdy;
    if (r) begin
      m_s = 0; m_gnt = 0; m_f = 0; m_valid = 0; m_busy = 0; m_ptr = 0;
    end else if (!m_busy) begin
      wn = pick(rq, start_ptr());
      if (wn >= 0) grant(wn);
    end else if (rdy) begin
      m_ptr = (m_s + 1) % 4;
      wn = pick(rq & ~4'(1 << m_s), start_ptr());
      if (wn >= 0) grant(wn);
      else begin m_gnt = 0; m_valid = 0; m_busy = 0; end
    end
    @(posedge clk); #1;
    chk("s", 32'(s), 32'(m_s));
    chk("gnt", 32'(gnt), 32'(m_gnt));
    chk("f", 32'(f), 32'(m_f));
    chk("valid", 32'(valid), 32'(m_valid));
  endtask

  initial begin
    rst = 1; req = 0; ready = 0; w0 = 3'b001; w1 = 3'b010; w2 = 3'b011; w3 = 3'b100;
    m_ptr = 0; m_s = 0; m_gnt = 0; m_f = 0; m_valid = 0; m_busy = 0;

    // reset state
    tick(1, 4'b0000, 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_gnt", 32'(gnt), 0);

    // single request, then handshake into IDLE
    tick(0, 4'b0010, 0);
    chk("single_s", 32'(s), 1);
    chk("single_f", 32'(f), 3'b010);
    chk("single_gnt", 32'(gnt), 4'b0010);
    tick(0, 4'b0000, 1);
    chk("single_done", 32'(valid), 0);

    // all requesting, ready held high: no bubbles
    tick(1, 4'b0000, 0);
    for (int i = 0; i < 8; i++) begin
      tick(0, 4'b1111, 1);
`ifdef ARB_FIXED_PRIO_EN
      chk("fair_s", 32'(s), 32'(i % 2));
`else
      chk("fair_s", 32'(s), 32'(i % 4));
`endif
      chk("fair_f", 32'(f), 32'(s + 1));
      chk("fair_valid", 32'(valid), 1);
    end

    // backpressure: frozen while ready=0, data and req changes ignored
    tick(1, 4'b0000, 0);
    tick(0, 4'b0100, 0);
    for (int i = 0; i < 3; i++) begin
      w2 = w2 + 3'd1;
      tick(0, 4'b0000, 0);
      chk("bp_s", 32'(s), 2);
      chk("bp_f", 32'(f), 3'b011);
    end
    tick(0, 4'b0000, 1);
    chk("bp_done", 32'(valid), 0);
    w2 = 3'b011;

    // mask and wrap: grant 3 with ptr=3, then 0 rather than 3
    tick(1, 4'b0000, 0);
    tick(0, 4'b0100, 0);
    tick(0, 4'b0000, 1);
    tick(0, 4'b1001, 0);
    tick(0, 4'b1001, 1);
`ifndef ARB_FIXED_PRIO_EN
    chk("wrap_s", 32'(s), 0);
    chk("wrap_f", 32'(f), 3'b001);
`endif

    // reset mid-BUSY with ptr away from 0, then pointer back at 0
    tick(0, 4'b0100, 1);
    tick(0, 4'b0100, 0);
    tick(1, 4'b0100, 0);
    chk("rstmid_valid", 32'(valid), 0);
    chk("rstmid_f", 32'(f), 0);
    tick(0, 4'b1111, 0);
    chk("rstmid_ptr", 32'(s), 0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      w0 = 3'($urandom); w1 = 3'($urandom); w2 = 3'($urandom); w3 = 3'($urandom);
      tick($urandom_range(0, 39) == 0, 4'($urandom), $urandom_range(0, 2) != 0);
      chk("inv_valid_gnt", 32'(valid), 32'(gnt != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
